// File: rtl/time_preset_sequencer_if.sv
// Host request/status signals plus the adjust bus driven into the time/date counter.
interface time_preset_sequencer_if;
    logic        start;
    logic        abort;
    logic [63:0] target;
    logic        adjust;
    logic [3:0]  select;
    logic        add;
    logic        clr;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, abort, target,
        input  adjust, select, add, clr, busy, done, err
    );

    modport slave (
        input  start, abort, target,
        output adjust, select, add, clr, busy, done, err
    );
endinterface

// File: rtl/time_preset_sequencer.sv
// Loads a BCD timestamp into the time counter through its adjust port using clear/add pulse bursts.
// Optional feature: define TPS_SKIP_MS_EN to only clear the ms digits instead of writing them.
module time_preset_sequencer #(
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                   CLOCK_50,
    input  logic                   rst,
    time_preset_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETTLE,
        S_HIGH,
        S_LOW,
        S_DONE,
        S_ERR
    } state_t;

    localparam int TMR_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
`ifdef TPS_SKIP_MS_EN
    localparam int FIRST_CHECKED = 2;
`else
    localparam int FIRST_CHECKED = 0;
`endif

    state_t         state_q, state_d;
    logic [63:0]    tgt_q, tgt_d;
    logic [2:0]     field_q, field_d;
    logic [2:0]     step_q, step_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           adjust_q, adjust_d;
    logic [3:0]     select_q, select_d;
    logic           add_q, add_d;
    logic           clr_q, clr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           nxt_found;
    logic [2:0]     nxt_field;
    logic [2:0]     nxt_step;
    logic [3:0]     nxt_cnt;
    logic           step_is_add;
    int             cur_pos;

    // Field f covers digits (15-2f, 14-2f); steps are CLR L, CLR H, ADD H, CLR L, ADD L.
    function automatic logic [3:0] step_count(input logic [63:0] t, input logic [2:0] f,
                                              input logic [2:0] s);
        logic [3:0] th;
        logic [3:0] tl;
        logic       base;
        logic [3:0] n;
        int         hi_idx;
        hi_idx = 15 - 2 * int'(f);
        th     = t[4*hi_idx +: 4];
        tl     = t[4*(hi_idx-1) +: 4];
        base   = ((f == 3'd2) || (f == 3'd3)) && (th == 4'd0);
        case (s)
            3'd2:    n = th;
            3'd4:    n = tl - {3'b000, base};
            default: n = 4'd1;
        endcase
`ifdef TPS_SKIP_MS_EN
        if ((f == 3'd7) && (s >= 3'd2)) n = 4'd0;
`endif
        return n;
    endfunction

    function automatic logic [3:0] step_select(input logic [2:0] f, input logic [2:0] s);
        logic [3:0] hi;
        hi = 4'd15 - {f, 1'b0};
        return ((s == 3'd1) || (s == 3'd2)) ? hi : hi - 4'd1;
    endfunction

    function automatic logic target_bad(input logic [63:0] t);
        logic [3:0] d [16];
        logic       bad;
        for (int k = 0; k < 16; k++) d[k] = t[4*k +: 4];
        bad = 1'b0;
        for (int k = FIRST_CHECKED; k < 16; k++) begin
            if (d[k] > 4'd9) bad = 1'b1;
        end
        if ((d[11] > 4'd1) || ((d[11] == 4'd1) && (d[10] > 4'd2)) ||
            ((d[11] == 4'd0) && (d[10] == 4'd0))) bad = 1'b1;
        if ((d[9] > 4'd3) || ((d[9] == 4'd3) && (d[8] > 4'd1)) ||
            ((d[9] == 4'd0) && (d[8] == 4'd0))) bad = 1'b1;
        if ((d[11] == 4'd0) && (d[10] == 4'd2) && (d[9] == 4'd3)) bad = 1'b1;
        if ((d[9] == 4'd3) && (d[8] == 4'd1) &&
            (((d[11] == 4'd0) && ((d[10] == 4'd4) || (d[10] == 4'd6) || (d[10] == 4'd9))) ||
             ((d[11] == 4'd1) && (d[10] == 4'd1)))) bad = 1'b1;
        if ((d[7] > 4'd2) || ((d[7] == 4'd2) && (d[6] > 4'd3))) bad = 1'b1;
        if ((d[5] > 4'd5) || (d[3] > 4'd5)) bad = 1'b1;
        return bad;
    endfunction

    // Zero-pulse steps are skipped, so the successor is the next position with a nonzero count.
    always_comb begin
        nxt_found = 1'b0;
        nxt_field = 3'd0;
        nxt_step  = 3'd0;
        cur_pos   = int'(field_q) * 5 + int'(step_q);
        for (int p = 0; p < 40; p++) begin
            if (!nxt_found && (p > cur_pos) &&
                (step_count(tgt_q, 3'(p / 5), 3'(p % 5)) != 4'd0)) begin
                nxt_found = 1'b1;
                nxt_field = 3'(p / 5);
                nxt_step  = 3'(p % 5);
            end
        end
        nxt_cnt     = step_count(tgt_q, nxt_field, nxt_step);
        step_is_add = (step_q == 3'd2) || (step_q == 3'd4);
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        field_d  = field_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        adjust_d = adjust_q;
        select_d = select_q;
        add_d    = 1'b0;
        clr_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (bus.abort && busy_q) begin
            state_d  = S_IDLE;
            adjust_d = 1'b1;
            select_d = 4'd0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        tgt_d   = bus.target;
                        busy_d  = 1'b1;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (target_bad(tgt_q)) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_ERR;
                    end else begin
                        field_d  = 3'd0;
                        step_d   = 3'd0;
                        cnt_d    = 4'd1;
                        adjust_d = 1'b0;
                        select_d = step_select(3'd0, 3'd0);
                        tmr_d    = TW'(SETTLE_CYC - 1);
                        state_d  = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (tmr_q == '0) begin
                        add_d   = step_is_add;
                        clr_d   = !step_is_add;
                        tmr_d   = TW'(PULSE_CYC - 1);
                        state_d = S_HIGH;
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
                S_HIGH: begin
                    if (tmr_q == '0) begin
                        cnt_d   = cnt_q - 4'd1;
                        tmr_d   = TW'(PULSE_CYC - 1);
                        state_d = S_LOW;
                    end else begin
                        add_d = add_q;
                        clr_d = clr_q;
                        tmr_d = tmr_q - TW'(1);
                    end
                end
                S_LOW: begin
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - TW'(1);
                    end else if (cnt_q != 4'd0) begin
                        add_d   = step_is_add;
                        clr_d   = !step_is_add;
                        tmr_d   = TW'(PULSE_CYC - 1);
                        state_d = S_HIGH;
                    end else if (nxt_found) begin
                        field_d  = nxt_field;
                        step_d   = nxt_step;
                        cnt_d    = nxt_cnt;
                        select_d = step_select(nxt_field, nxt_step);
                        tmr_d    = TW'(SETTLE_CYC - 1);
                        state_d  = S_SETTLE;
                    end else begin
                        adjust_d = 1'b1;
                        select_d = 4'd0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tgt_q    <= '0;
            field_q  <= '0;
            step_q   <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            adjust_q <= 1'b1;
            select_q <= '0;
            add_q    <= 1'b0;
            clr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            field_q  <= field_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            adjust_q <= adjust_d;
            select_q <= select_d;
            add_q    <= add_d;
            clr_q    <= clr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.adjust = adjust_q;
    assign bus.select = select_q;
    assign bus.add    = add_q;
    assign bus.clr    = clr_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_time_preset_sequencer.sv
// Scoreboard bench for time_preset_sequencer driving a behavioural model of the time counter.
module tb_time_preset_sequencer;

    localparam int PULSE_CYC  = 2;
    localparam int SETTLE_CYC = 1;
`ifdef TPS_SKIP_MS_EN
    localparam bit SKIP_MS = 1'b1;
`else
    localparam bit SKIP_MS = 1'b0;
`endif

    localparam logic [63:0] T_LEAP  = 64'h2024_0229_2359_5999;
    localparam logic [63:0] T_OCT5  = 64'h2000_1005_0000_0000;
    localparam logic [63:0] T_MS47  = 64'h2000_1005_0000_0047;
    localparam logic [63:0] T_MON13 = 64'h2024_1301_1200_0000;
    localparam logic [63:0] T_APR31 = 64'h2024_0431_1200_0000;
    localparam logic [63:0] T_HR24  = 64'h2024_0101_2400_0000;

    typedef struct {
        bit          is_err;
        int          start_cyc;
        int          latency;
        logic [63:0] counter;
        logic [15:0] adds_mask;
        logic [63:0] adds_exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    time_preset_sequencer_if bus();

    time_preset_sequencer #(
        .PULSE_CYC (PULSE_CYC),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .CLOCK_50(clk),
        .rst     (rst),
        .bus     (bus)
    );

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [3:0] model_dig [16];
    int         adds_seen [16];
    int         pulses_seen;
    int         adj_low;
    int         busy_cyc;
    logic       add_prev  = 1'b0;
    logic       clr_prev  = 1'b0;
    logic       busy_prev = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] tgt, input bit expect_resp, input bit is_err,
                                 input int latency, input logic [15:0] mask, input logic [63:0] adds);
        exp_t e;
        @(negedge clk);
        bus.target = tgt;
        bus.start  = 1'b1;
        if (expect_resp) begin
            e.is_err    = is_err;
            e.start_cyc = cyc;
            e.latency   = latency;
            e.counter   = SKIP_MS ? {tgt[63:8], 8'h00} : tgt;
            e.adds_mask = mask;
            e.adds_exp  = adds;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_adjust"}, 64'(bus.adjust), 64'd1);
        checkOutput({tag, "_select"}, 64'(bus.select), 64'd0);
        checkOutput({tag, "_add"},    64'(bus.add),    64'd0);
        checkOutput({tag, "_clr"},    64'(bus.clr),    64'd0);
        checkOutput({tag, "_busy"},   64'(bus.busy),   64'd0);
        checkOutput({tag, "_done"},   64'(bus.done),   64'd0);
        checkOutput({tag, "_err"},    64'(bus.err),    64'd0);
    endtask

    // Monitor: updates the counter model on strobe rising edges and scores every done/err pulse.
    initial begin
        exp_t        e;
        logic [63:0] snap;
        forever begin
            @(negedge clk);
            if (bus.busy && !busy_prev) begin
                for (int k = 0; k < 16; k++) adds_seen[k] = 0;
                pulses_seen = 0;
                adj_low     = 0;
                busy_cyc    = 0;
            end
            if (bus.add && !add_prev) begin
                pulses_seen++;
                adds_seen[bus.select]++;
                if (!bus.adjust)
                    model_dig[bus.select] = (model_dig[bus.select] == 4'd9) ? 4'd0
                                                                            : model_dig[bus.select] + 4'd1;
            end
            if (bus.clr && !clr_prev) begin
                pulses_seen++;
                if (!bus.adjust) begin
                    if ((bus.select == 4'd10 && model_dig[11] == 4'd0) ||
                        (bus.select == 4'd8 && model_dig[9] == 4'd0))
                        model_dig[bus.select] = 4'd1;
                    else
                        model_dig[bus.select] = 4'd0;
                end
            end
            if (!bus.adjust) adj_low++;
            if (bus.busy) busy_cyc++;
            if (bus.add && bus.clr) checkOutput("add_clr_exclusive", 64'd1, 64'd0);
            if (bus.done || bus.err) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_response", 64'({bus.done, bus.err}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("resp_kind", 64'({bus.done, bus.err}), e.is_err ? 64'd1 : 64'd2);
                    checkOutput("resp_latency", 64'(cyc - e.start_cyc), 64'(e.latency));
                    checkOutput("busy_cycles", 64'(busy_cyc), e.is_err ? 64'd1 : 64'(e.latency - 1));
                    checkOutput("adjust_low_cycles", 64'(adj_low), e.is_err ? 64'd0 : 64'(e.latency - 2));
                    if (e.is_err) begin
                        checkOutput("err_pulses", 64'(pulses_seen), 64'd0);
                    end else begin
                        for (int k = 0; k < 16; k++) snap[4*k +: 4] = model_dig[k];
                        checkOutput("counter_read", snap, e.counter);
                        checkOutput("done_adjust", 64'(bus.adjust), 64'd1);
                        checkOutput("done_select", 64'(bus.select), 64'd0);
                        for (int k = 0; k < 16; k++) begin
                            if (e.adds_mask[k])
                                checkOutput($sformatf("adds_sel%0d", k), 64'(adds_seen[k]),
                                            64'(e.adds_exp[4*k +: 4]));
                        end
                    end
                end
            end
            add_prev  = bus.add;
            clr_prev  = bus.clr;
            busy_prev = bus.busy;
        end
    end

    initial begin
        int n;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.target = '0;
        for (int k = 0; k < 16; k++) model_dig[k] = 4'd7;
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        $display("[TB] full load of 2024-02-29 23:59:59.99");
        applyStimulus(T_LEAP, 1'b1, 1'b0, SKIP_MS ? 341 : 420, 16'h0000, 64'd0);
        waitDrain(1000);

        $display("[TB] rejected targets");
        applyStimulus(T_MON13, 1'b1, 1'b1, 2, 16'h0000, 64'd0);
        waitDrain(20);
        applyStimulus(T_APR31, 1'b1, 1'b1, 2, 16'h0000, 64'd0);
        waitDrain(20);
        applyStimulus(T_HR24, 1'b1, 1'b1, 2, 16'h0000, 64'd0);
        waitDrain(20);

        $display("[TB] day 05 month 10 add counts and step timing");
        applyStimulus(T_OCT5, 1'b1, 1'b0, SKIP_MS ? 148 : 153, 16'h0E00, 64'h0000_1000_0000_0000);
        waitDrain(1000);

        $display("[TB] start while busy is ignored");
        applyStimulus(T_LEAP, 1'b1, 1'b0, SKIP_MS ? 341 : 420, 16'h0000, 64'd0);
        repeat (40) @(negedge clk);
        bus.target = T_OCT5;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.target = '0;
        waitDrain(1000);

        $display("[TB] simultaneous abort and start in idle");
        @(negedge clk);
        bus.target = T_OCT5;
        bus.start  = 1'b1;
        bus.abort  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checkOutput("abort_start_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);

        $display("[TB] abort during an add pulse in the hour field");
        applyStimulus(T_LEAP, 1'b0, 1'b0, 0, 16'h0000, 64'd0);
        n = 0;
        while (!((bus.select == 4'd6 || bus.select == 4'd7) && bus.add) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_hour_add_reached", 64'(n < 2000), 64'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("abort_add",    64'(bus.add),    64'd0);
        checkOutput("abort_clr",    64'(bus.clr),    64'd0);
        checkOutput("abort_adjust", 64'(bus.adjust), 64'd1);
        checkOutput("abort_busy",   64'(bus.busy),   64'd0);
        repeat (5) @(negedge clk);
        checkOutput("abort_stays_idle", 64'(bus.busy), 64'd0);
        applyStimulus(T_OCT5, 1'b1, 1'b0, SKIP_MS ? 148 : 153, 16'h0E00, 64'h0000_1000_0000_0000);
        waitDrain(1000);

        $display("[TB] reset mid-sequence");
        applyStimulus(T_LEAP, 1'b0, 1'b0, 0, 16'h0000, 64'd0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("midreset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] ms field handling");
        applyStimulus(T_MS47, 1'b1, 1'b0, SKIP_MS ? 148 : 199, 16'h0003,
                      SKIP_MS ? 64'd0 : 64'h0000_0000_0000_0047);
        waitDrain(1000);

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
